// File: rtl/johnson_counter_gen.sv
// -----------------------------------------------------------------------------
// johnson_counter_gen
//
// Parametrised Johnson / ring counter with a programmable prescaler.
//
// Features:
//   - Johnson (twisted ring) mode: 2*WIDTH states.
//   - Ring (one-hot) mode: WIDTH states, plus an all-zero idle state.
//   - Forward / reverse direction.
//   - Prescaler: one step every (div+1) enabled cycles.
//   - Synchronous parallel load.
//   - Binary phase index and a one-cycle wrap pulse.
//   - Illegal-state self-correction with a sticky error flag.
//
// Ports:
//   i_clk       clock; all state changes on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_en        count enable; low freezes the prescaler and the counter
//   i_mode      0 = Johnson, 1 = ring
//   i_dir       0 = forward (shift toward MSB), 1 = reverse
//   i_load      synchronous parallel load strobe (beats a tick)
//   i_load_val  value loaded into the counter
//   i_div       prescaler compare value
//   o_q         counter state
//   o_phase     binary index of the current state
//   o_wrap      one-cycle pulse after a step that wraps the sequence
//   o_err       sticky illegal-state flag
// -----------------------------------------------------------------------------
module johnson_counter_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic                          i_mode,
  input  logic                          i_dir,
  input  logic                          i_load,
  input  logic [WIDTH-1:0]              i_load_val,
  input  logic [DIV_W-1:0]              i_div,
  output logic [WIDTH-1:0]              o_q,
  output logic [$clog2(2*WIDTH)-1:0]    o_phase,
  output logic                          o_wrap,
  output logic                          o_err
);

  localparam int unsigned PW = $clog2(2 * WIDTH);

  // Last phase index in each mode.
  localparam logic [PW-1:0] JLast = PW'(2 * WIDTH - 1);
  localparam logic [PW-1:0] RLast = PW'(WIDTH - 1);

  typedef struct packed {
    logic          legal;
    logic [PW-1:0] idx;
  } dec_t;

  // Classify a value as a legal state of the given mode and return its index.
  // Ring all-zero is reported as not legal here; callers treat idle separately.
  function automatic dec_t f_decode(input logic [WIDTH-1:0] v, input logic ring);
    dec_t             res;
    logic [WIDTH-1:0] m;
    res.legal = 1'b0;
    res.idx   = '0;
    if (ring) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (v == (WIDTH'(1) << k)) begin
          res.legal = 1'b1;
          res.idx   = PW'(k);
        end
      end
    end else begin
      // Filling phase: k ones in the LSBs.
      m = '0;
      for (int unsigned k = 0; k <= WIDTH; k++) begin
        if (v == m) begin
          res.legal = 1'b1;
          res.idx   = PW'(k);
        end
        m = {m[WIDTH-2:0], 1'b1};
      end
      // Draining phase: ones in the top WIDTH-j bits, zeros below.
      m = '1;
      for (int unsigned j = 1; j < WIDTH; j++) begin
        m = m << 1;
        if (v == m) begin
          res.legal = 1'b1;
          res.idx   = PW'(WIDTH + j);
        end
      end
    end
    return res;
  endfunction

  // State registers
  logic [DIV_W-1:0] r_presc;
  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_phase;
  logic             r_wrap;
  logic             r_err;

  // Next-state and helper wires
  logic [DIV_W-1:0] w_presc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [PW-1:0]    w_phase_nxt;
  logic             w_wrap_nxt;
  logic             w_err_nxt;

  logic             w_tick;
  logic             w_idle;
  dec_t             w_cur;
  dec_t             w_ld;
  logic             w_ld_legal;
  logic [PW-1:0]    w_last;
  logic [WIDTH-1:0] w_step_q;
  logic [PW-1:0]    w_step_phase;
  logic             w_step_wrap;

  assign w_tick = i_en & (r_presc == i_div);

  // Legality is always judged in the mode presented now, so a mode change
  // re-evaluates the held value at the next tick or load.
  assign w_cur  = f_decode(r_q, i_mode);
  assign w_ld   = f_decode(i_load_val, i_mode);
  assign w_idle = i_mode & (r_q == '0);

  // Loading zero in ring mode parks the counter in its idle state.
  assign w_ld_legal = w_ld.legal | (i_mode & (i_load_val == '0));

  assign w_last = i_mode ? RLast : JLast;

  // Shift network for one step from a legal state.
  always_comb begin
    w_step_q = r_q;
    unique case ({i_mode, i_dir})
      2'b00:   w_step_q = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
      2'b01:   w_step_q = {~r_q[0], r_q[WIDTH-1:1]};
      2'b10:   w_step_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      2'b11:   w_step_q = {r_q[0], r_q[WIDTH-1:1]};
      default: w_step_q = r_q;
    endcase
  end

  // Phase arithmetic follows the shift; wrap marks the seam between the last
  // phase and phase 0 in either direction.
  always_comb begin
    w_step_phase = w_cur.idx;
    w_step_wrap  = 1'b0;
    if (i_dir) begin
      if (w_cur.idx == '0) begin
        w_step_phase = w_last;
        w_step_wrap  = 1'b1;
      end else begin
        w_step_phase = w_cur.idx - 1'b1;
      end
    end else begin
      if (w_cur.idx == w_last) begin
        w_step_phase = '0;
        w_step_wrap  = 1'b1;
      end else begin
        w_step_phase = w_cur.idx + 1'b1;
      end
    end
  end

  // Next-state selection: load > tick > hold.
  always_comb begin
    w_presc_nxt = r_presc;
    w_q_nxt     = r_q;
    w_phase_nxt = r_phase;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = r_err;

    if (i_load) begin
      w_presc_nxt = '0;
      w_q_nxt     = i_load_val;
      w_phase_nxt = w_ld_legal ? w_ld.idx : '0;
      w_err_nxt   = ~w_ld_legal;
    end else if (w_tick) begin
      w_presc_nxt = '0;
      if (w_idle) begin
        w_q_nxt     = WIDTH'(1);
        w_phase_nxt = '0;
      end else if (!w_cur.legal) begin
        // Self-correct to the phase-0 state of the current mode.
        w_q_nxt     = i_mode ? WIDTH'(1) : '0;
        w_phase_nxt = '0;
        w_err_nxt   = 1'b1;
      end else begin
        w_q_nxt     = w_step_q;
        w_phase_nxt = w_step_phase;
        w_wrap_nxt  = w_step_wrap;
      end
    end else if (i_en) begin
      // Free-running increment: if div was lowered below the count, the
      // prescaler rolls over through 2^DIV_W before it matches again.
      w_presc_nxt = r_presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_q     <= '0;
      r_phase <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_q     <= w_q_nxt;
      r_phase <= w_phase_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_q     = r_q;
  assign o_phase = r_phase;
  assign o_wrap  = r_wrap;
  assign o_err   = r_err;

endmodule

// File: tb/tb_johnson_counter_gen.sv
// -----------------------------------------------------------------------------
// tb_johnson_counter_gen
//
// Self-checking bench for johnson_counter_gen (WIDTH=4, DIV_W=8): a table of
// directed vectors, hand-written multi-cycle sequences, and a randomized run
// against a phase-table reference model.
// -----------------------------------------------------------------------------
module tb_johnson_counter_gen;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [7:0] div = 8'd0;
  logic [3:0] q;
  logic [2:0] phase;
  logic       wrap;
  logic       err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  johnson_counter_gen #(
    .WIDTH(4),
    .DIV_W(8)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_mode    (mode),
    .i_dir     (dir),
    .i_load    (load),
    .i_load_val(load_val),
    .i_div     (div),
    .o_q       (q),
    .o_phase   (phase),
    .o_wrap    (wrap),
    .o_err     (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input int eq, input int eph, input int ew,
                         input int ee);
    chk({name, ".q"}, int'(q), eq);
    chk({name, ".phase"}, int'(phase), eph);
    chk({name, ".wrap"}, int'(wrap), ew);
    chk({name, ".err"}, int'(err), ee);
  endtask

  // Async reset pulse; outputs checked before any clock edge can occur.
  task automatic do_reset(input string name);
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all(name, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model (phase-table view) ----------------
  int m_q, m_ph, m_wrap, m_err, m_presc;

  function automatic int nst(input bit m);
    return m ? W : 2 * W;
  endfunction

  // Counter pattern for phase p in mode m.
  function automatic int st(input int p, input bit m);
    if (m) return 1 << p;
    if (p <= W) return (1 << p) - 1;
    return ((1 << W) - 1) & ~((1 << (p - W)) - 1);
  endfunction

  function automatic int find(input int v, input bit m);
    for (int p = 0; p < nst(m); p++) if (st(p, m) == v) return p;
    return -1;
  endfunction

  task automatic model_step();
    int idx;
    int n;
    bit tick;
    tick = en && (m_presc == int'(div));
    n = nst(mode);
    m_wrap = 0;
    if (load) begin
      m_presc = 0;
      m_q = int'(load_val);
      idx = find(m_q, mode);
      if (idx < 0 && mode && m_q == 0) idx = 0;
      m_err = (idx < 0) ? 1 : 0;
      m_ph = (idx < 0) ? 0 : idx;
    end else if (tick) begin
      m_presc = 0;
      if (mode && m_q == 0) begin
        m_q = 1;
        m_ph = 0;
      end else begin
        idx = find(m_q, mode);
        if (idx < 0) begin
          m_q = st(0, mode);
          m_ph = 0;
          m_err = 1;
        end else begin
          m_wrap = dir ? (idx == 0) : (idx == n - 1);
          m_ph = dir ? (idx + n - 1) % n : (idx + 1) % n;
          m_q = st(m_ph, mode);
        end
      end
    end else if (en) begin
      m_presc = (m_presc + 1) % 256;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit   en;
    bit   mode;
    bit   dir;
    bit   load;
    logic [3:0] lv;
    logic [3:0] q;
    int   ph;
    bit   wrap;
    bit   err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit e, input bit m, input bit d, input bit l,
                              input logic [3:0] lv, input logic [3:0] eq, input int eph,
                              input bit ew, input bit ee);
    vec_t v;
    v.en = e; v.mode = m; v.dir = d; v.load = l; v.lv = lv;
    v.q = eq; v.ph = eph; v.wrap = ew; v.err = ee;
    return v;
  endfunction

  logic [3:0] exp_rev[8];
  logic [3:0] exp_ring[5];

  initial begin
    // Johnson forward full cycle, div=0
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b0011, 2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b0111, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b1111, 4, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b1110, 5, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b1100, 6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b1000, 7, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b0001, 1, 0, 0));
    // Illegal load, correction, legal load clears err
    tbl.push_back(mk(1, 0, 0, 1, 4'b0101, 4'b0101, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 4'b0011, 4'b0011, 2, 0, 0));
    // Switch to ring: 0011 is illegal there
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'b0010, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'b0100, 2, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'b1000, 3, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'h0, 4'b0001, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 0, 4'h0, 4'b1000, 3, 1, 1));
    tbl.push_back(mk(1, 1, 1, 0, 4'h0, 4'b0100, 2, 0, 1));
    // Back to Johnson by loading a legal top-filled state
    tbl.push_back(mk(1, 0, 0, 1, 4'b1000, 4'b1000, 7, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 0));

    exp_rev  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    exp_ring = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // ---- table run ----
    do_reset("reset0");
    div = 8'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; mode = tbl[i].mode; dir = tbl[i].dir;
      load = tbl[i].load; load_val = tbl[i].lv;
      cyc();
      chk_all($sformatf("tbl[%0d]", i), int'(tbl[i].q), tbl[i].ph, int'(tbl[i].wrap),
              int'(tbl[i].err));
    end
    load = 1'b0;
    en = 1'b0;

    // ---- Johnson reverse from reset ----
    do_reset("reset_rev");
    mode = 1'b0; dir = 1'b1; div = 8'd0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_all($sformatf("jrev[%0d]", i), int'(exp_rev[i]), 7 - i, (i == 0) ? 1 : 0, 0);
    end
    en = 1'b0;

    // ---- Ring from idle ----
    do_reset("reset_ring");
    mode = 1'b1; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_all($sformatf("ring[%0d]", i), int'(exp_ring[i]), i % 4, (i == 4) ? 1 : 0, 0);
    end
    dir = 1'b1;
    cyc();
    chk_all("ring_rev_wrap", 4'b1000, 3, 1, 0);
    en = 1'b0;

    // ---- Prescaler, enable hold, load resets prescaler ----
    do_reset("reset_div");
    mode = 1'b0; dir = 1'b0; div = 8'd2; en = 1'b1;
    cyc(); cyc();
    chk("div_pre_tick.q", int'(q), 0);
    cyc();
    chk("div_tick.q", int'(q), 1);
    cyc();                                   // presc 0 -> 1
    en = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("en_hold.q", int'(q), 1);
    en = 1'b1;
    cyc();                                   // presc 1 -> 2
    chk("en_resume.q", int'(q), 1);
    cyc();                                   // tick
    chk_all("en_resume_tick", 4'b0011, 2, 0, 0);
    cyc();                                   // presc 0 -> 1
    load = 1'b1; load_val = 4'b0111;
    cyc();
    load = 1'b0;
    chk_all("load_mid", 4'b0111, 3, 0, 0);
    cyc(); cyc();
    chk("load_presc_reset.q", int'(q), 4'b0111);
    cyc();
    chk_all("load_presc_tick", 4'b1111, 4, 0, 0);

    // ---- Async reset mid-count ----
    div = 8'd0;
    do_reset("reset_mid0");
    cyc(); cyc(); cyc();
    chk("mid_pre.q", int'(q), 4'b0111);
    do_reset("reset_mid");
    en = 1'b0;

    // ---- Randomized run against the reference model ----
    do_reset("reset_rand");
    m_q = 0; m_ph = 0; m_wrap = 0; m_err = 0; m_presc = 0;
    mode = 1'b0; dir = 1'b0; div = 8'd0;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0) div = 8'($urandom_range(0, 3));
      load = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk_all($sformatf("rand[%0d]", i), m_q, m_ph, m_wrap, m_err);
    end
    load = 1'b0;
    en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/johnson_counter_gen.md
Name: johnson_counter_gen

Overview:
Parametrised successor to the fixed 4-bit Johnson counter in the tt_um_spi_serv project. Generalises width and adds a selectable Johnson/ring mode, direction control, programmable clock prescaler, parallel load, a binary phase index, a wrap pulse and illegal-state self-correction. It sits behind the tile I/O wrapper, and the wrapper maps its ports onto ui_in/uo_out/uio.

Parameters:
WIDTH, 4, counter register width; legal range 2..16; Johnson mode has 2*WIDTH states, ring mode has WIDTH states.
DIV_W, 8, prescaler compare width.
PW, $clog2(2*WIDTH), phase index width (localparam).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  count enable; low freezes prescaler and counter.
mode  in  1  0 = Johnson (twisted ring), 1 = ring (one-hot).
dir  in  1  0 = forward (shift toward MSB), 1 = reverse.
load  in  1  synchronous parallel load strobe.
load_val  in  WIDTH  value loaded into q.
div  in  DIV_W  step every div+1 enabled cycles.
q  out  WIDTH  counter state (registered).
phase  out  PW  binary index of current state (registered).
wrap  out  1  one-cycle pulse on sequence wrap (registered).
err  out  1  sticky illegal-state flag.

Behaviour:
- Reset (async, rst_n=0): q=0, phase=0, wrap=0, err=0, prescaler=0.
- Prescaler: tick = en & (presc==div); on tick presc<=0, else if en presc<=presc+1. div=0 gives a tick every enabled cycle. en=0 holds presc. A mid-count change of div takes effect immediately. If presc>div, presc counts up through its wrap at 2^DIV_W and then reaches div.
- Priority per cycle: load > tick > hold.
- load: q<=load_val, presc<=0, wrap<=0, err<=0 if load_val is legal for the current mode, else err<=1. phase<=index of load_val (0 if illegal).
- Johnson legal states: k ones in the LSBs (phase k, k=0..WIDTH), or ones in the top WIDTH-j bits with zeros below (phase WIDTH+j, j=1..WIDTH-1).
- Johnson step: forward q<={q[W-2:0],~q[W-1]}; reverse q<={~q[0],q[W-1:1]}.
- Ring legal states: exactly one bit set, phase = bit index. All-zero is the idle state: a tick moves it to 0..01 (phase 0) with no err and no wrap.
- Ring step: forward rotate left, reverse rotate right.
- Tick on an illegal state: q<=phase-0 state (Johnson 0, ring 0..01), phase<=0, err<=1, no wrap.
- wrap: 1 for the cycle after a tick that moves forward from the last phase (2W-1 Johnson, W-1 ring) to phase 0, or reverse from phase 0 to the last phase. Otherwise 0.
- phase always tracks q in the same cycle (registered together); latency from tick to q/phase/wrap is 1 clock.
- A mode change takes effect at the next tick or load; the current q is re-judged for legality in the new mode at that point. Example: Johnson 0011 in ring mode is illegal, so the tick corrects it and sets err.
- A dir change takes effect on the next tick with no glitch.
- err clears only on reset or on a load of a legal value.
- Reset asserted mid-count forces the reset values immediately, regardless of clk.

Test Plan:
- WIDTH=4, mode=0, dir=0, div=0, en=1 from reset: q steps 0000,0001,0011,0111,1111,1110,1100,1000,0000; phase 0..7 then 0; wrap=1 only in the cycle q returns to 0000.
- Same setup with dir=1: q 0000,1000,1100,1110,1111,0111,0011,0001; wrap=1 on 0000→1000 (phase 7); err stays 0.
- mode=1 from reset, dir=0: q 0000→0001→0010→0100→1000→0001, with wrap on the return to 0001 and no wrap on idle→0001; mode=1, dir=1 from 0001: q→1000 with wrap.
- div=2, en toggled: q advances once per 3 enabled cycles; dropping en for 5 cycles holds q and presc; assert load=1 with tick coincident: load wins and presc resets.
- Load 0101 in mode=0: err=1, phase=0; next tick gives q=0000, err stays 1; load 0011 gives err=0, phase=2.
- Reset pulse asserted asynchronously mid-count (q=0111): q=0, wrap=0, err=0 before the next clk edge.
